sprite_line_eval: RTL and testbench
===================================

Name: sprite_line_eval

Overview:
- Per-scanline sprite evaluator, directly upstream of the tile drawing stage.
- On each line-start pulse, scans all SPRITE_NUM entries of the main sprite attribute RAM (OAM) and selects up to LINE_SPRITE_MAX sprites whose 8-row extent covers the next game line.
- Writes the selected entries into one bank of the double-buffered sprite view RAM. The drawing stage reads the other bank, indexed per slot, during the current line.

Parameters:
SPRITE_NUM, 64, number of OAM entries scanned per line
LINE_SPRITE_MAX, 8, view RAM slots per bank (per line)
TILE_H, 8, sprite height in lines
Y_W, 8, width of game-relative Y coordinates

Ports:
clk  in  1  system clock
rstn  in  1  reset, synchronous, active-low
lineStart  in  1  one-cycle pulse at start of each VGA line
nextLineY  in  Y_W  game-relative Y of line to evaluate; sampled on lineStart
oamRdEn  out  1  OAM read strobe
oamAddr  out  log2(SPRITE_NUM)  OAM entry index
oamData  in  32  {posX,posY,tileIndex,attr}; valid cycle after oamRdEn
viewWrEn  out  1  view RAM write strobe
viewWrBank  out  1  bank being written (= ~dispBank)
viewWrAddr  out  log2(LINE_SPRITE_MAX)  slot index
viewWrData  out  32  entry written
dispBank  out  1  bank the drawing stage reads this line
dispSlotValid  out  LINE_SPRITE_MAX  valid mask for dispBank slots
evalBusy  out  1  scan/fill in progress
overflow  out  1  >LINE_SPRITE_MAX hits on last evaluated line
overrun  out  1  sticky: lineStart arrived while busy

Behaviour:
- Reset (rstn=0 at clk edge, any state): FSM=IDLE, all outputs 0, dispBank=0, dispSlotValid=0, internal hit count=0. Reset mid-scan aborts with no further writes.
- FSM states: IDLE, SCAN, FILL.
- lineStart in any state:
  - dispBank toggles.
  - dispSlotValid loads the write-bank mask built so far.
  - overflow loads the pending flag.
  - nextLineY is latched.
  - hit count clears; FSM enters SCAN with oamAddr=0.
- lineStart while evalBusy=1: also sets overrun; the partial result is displayed.
- SCAN:
  - Issues oamRdEn=1 with oamAddr incrementing 0..SPRITE_NUM-1, one per cycle.
  - Each returned entry is tested on the next cycle (1-stage pipe).
  - Hit test uses 9-bit arithmetic: nextLineY >= posY AND {0,nextLineY} < {0,posY}+TILE_H. There is no wrap-around: posY=250 does not hit line 2.
  - A hit drives viewWrEn=1, viewWrAddr=hit count, viewWrData=oamData unchanged, sets the mask bit, and increments hit count.
  - A hit with hit count already = LINE_SPRITE_MAX sets pending overflow, writes nothing, and goes to FILL; the in-flight read is discarded.
  - After the entry at index SPRITE_NUM-1 is tested, go to FILL.
- FILL: writes 32'hFFFF_FFFF to slots hitCount..LINE_SPRITE_MAX-1, one per cycle, mask bits stay 0, then goes to IDLE. If all slots are full, FILL lasts 0 cycles.
- evalBusy=1 in SCAN and FILL.
- Worst-case latency from lineStart to IDLE: SPRITE_NUM+1+LINE_SPRITE_MAX cycles (73 at defaults).
- Priority: a lower OAM index gets a lower slot.
- Outputs viewWr* and oamRd* are registered.

Decomposition:
- Shared define file holds SPRITE_NUM_MAX, TILE_H, BYTE, the field slice positions of the 32-bit sprite entry, and the empty-slot constant 32'hFFFF_FFFF.
- One natural sub-module: sprite_y_hit, the combinational 9-bit range compare, reusable by the drawing stage.

Test Plan:
- Reset: hold rstn=0 3 cycles -> all outputs 0; lineStart with rstn=0 ignored.
- nextLineY=20; OAM[3].posY=13, [10].posY=20, [40].posY=12, rest 0xF0 -> slots 0,1 = entries 3,10; entry 40 misses; slots 2..7 = FFFF_FFFF; on next lineStart dispSlotValid=8'b0000_0011, dispBank flips.
- Boundaries: posY=nextLineY-7 hits; posY=nextLineY-8 misses; posY=nextLineY+1 misses; posY=250 with nextLineY=2 misses.
- Overflow: 12 entries at posY=nextLineY -> 8 writes (entries 0..7 by OAM order), no FILL writes, overflow=1 after next lineStart; a following line with 3 hits clears it.
- lineStart pulsed 30 cycles after a previous one -> overrun=1 (sticky until reset), scan restarts at oamAddr=0, bank toggles.
- Reset asserted mid-SCAN -> next cycle viewWrEn=0, evalBusy=0, dispSlotValid=0.

Source files
------------

// File: rtl/sprite_line_eval_pkg.sv
// Shared constants and field layout for the per-line sprite evaluator.
// Sprite entry is {posX, posY, tileIndex, attr}, one byte each.
package sprite_line_eval_pkg;

    localparam int SPRITE_NUM      = 64;
    localparam int SPRITE_NUM_MAX  = 64;
    localparam int LINE_SPRITE_MAX = 8;
    localparam int TILE_H          = 8;
    localparam int BYTE            = 8;
    localparam int Y_W             = BYTE;

    localparam int OAM_AW = $clog2(SPRITE_NUM_MAX);
    localparam int SLOT_W = $clog2(LINE_SPRITE_MAX);
    localparam int CNT_W  = SLOT_W + 1;

    localparam int POSX_LSB = 24;
    localparam int POSY_LSB = 16;
    localparam int TILE_LSB = 8;
    localparam int ATTR_LSB = 0;

    localparam logic [31:0] EMPTY_SLOT = 32'hFFFF_FFFF;

    function automatic logic [Y_W-1:0] pos_y(input logic [31:0] e);
        return e[POSY_LSB +: Y_W];
    endfunction

endpackage

// File: rtl/sprite_line_eval_if.sv
// Line-control, OAM read and view RAM write signals of the evaluator.
interface sprite_line_eval_if;
    import sprite_line_eval_pkg::*;

    logic                       lineStart;
    logic [Y_W-1:0]             nextLineY;
    logic                       oamRdEn;
    logic [OAM_AW-1:0]          oamAddr;
    logic [31:0]                oamData;
    logic                       viewWrEn;
    logic                       viewWrBank;
    logic [SLOT_W-1:0]          viewWrAddr;
    logic [31:0]                viewWrData;
    logic                       dispBank;
    logic [LINE_SPRITE_MAX-1:0] dispSlotValid;
    logic                       evalBusy;
    logic                       overflow;
    logic                       overrun;

    modport slave (
        input  lineStart, nextLineY, oamData,
        output oamRdEn, oamAddr, viewWrEn, viewWrBank, viewWrAddr,
        output viewWrData, dispBank, dispSlotValid, evalBusy,
        output overflow, overrun
    );

    modport master (
        output lineStart, nextLineY, oamData,
        input  oamRdEn, oamAddr, viewWrEn, viewWrBank, viewWrAddr,
        input  viewWrData, dispBank, dispSlotValid, evalBusy,
        input  overflow, overrun
    );

endinterface

// File: rtl/sprite_line_eval_y_hit.sv
// Vertical coverage test of an 8-row sprite; 9-bit so posY near 255 never wraps.
module sprite_y_hit #(
    parameter int YW = 8,
    parameter int H  = 8
) (
    input  logic [YW-1:0] i_line_y,
    input  logic [YW-1:0] i_pos_y,
    output logic          o_hit
);

    logic [YW:0] w_top;

    assign w_top = {1'b0, i_pos_y} + (YW+1)'(H);
    assign o_hit = (i_line_y >= i_pos_y) && ({1'b0, i_line_y} < w_top);

endmodule

// File: rtl/sprite_line_eval.sv
// Scans OAM each line and fills the back bank of the sprite view RAM,
// lower OAM index taking the lower slot; unused slots get EMPTY_SLOT.
module sprite_line_eval
    import sprite_line_eval_pkg::*;
(
    input  logic                clk,
    input  logic                rstn,
    sprite_line_eval_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    localparam logic [OAM_AW-1:0] LAST_ADDR = OAM_AW'(SPRITE_NUM-1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(LINE_SPRITE_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LINE_SPRITE_MAX-1);

    logic [1:0]                 r_state;
    logic [Y_W-1:0]             r_line_y;
    logic [CNT_W-1:0]           r_cnt;
    logic [LINE_SPRITE_MAX-1:0] r_mask;
    logic                       r_ovf_pend;
    logic                       r_dvld;
    logic [OAM_AW-1:0]          r_daddr;
    logic                       r_rd_en;
    logic [OAM_AW-1:0]          r_rd_addr;
    logic                       r_wr_en;
    logic                       r_wr_bank;
    logic [SLOT_W-1:0]          r_wr_addr;
    logic [31:0]                r_wr_data;
    logic                       r_disp_bank;
    logic [LINE_SPRITE_MAX-1:0] r_disp_valid;
    logic                       r_ovf;
    logic                       r_overrun;

    logic             w_hit;
    logic             w_busy;
    logic             w_last;
    logic             w_full;
    logic [CNT_W-1:0] w_cnt_nx;

    sprite_y_hit #(.YW(Y_W), .H(TILE_H)) u_y_hit (
        .i_line_y (r_line_y),
        .i_pos_y  (pos_y(bus.oamData)),
        .o_hit    (w_hit)
    );

    assign w_busy   = (r_state != S_IDLE);
    assign w_last   = (r_daddr == LAST_ADDR);
    assign w_full   = (r_cnt == CNT_FULL);
    assign w_cnt_nx = r_cnt + CNT_W'(w_hit);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_line_y     <= '0;
            r_cnt        <= '0;
            r_mask       <= '0;
            r_ovf_pend   <= 1'b0;
            r_dvld       <= 1'b0;
            r_daddr      <= '0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_bank    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_disp_bank  <= 1'b0;
            r_disp_valid <= '0;
            r_ovf        <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_dvld  <= r_rd_en;
            r_daddr <= r_rd_addr;
            if (bus.lineStart) begin
                r_disp_bank  <= ~r_disp_bank;
                r_disp_valid <= r_mask;
                r_ovf        <= r_ovf_pend;
                r_ovf_pend   <= 1'b0;
                r_mask       <= '0;
                r_line_y     <= bus.nextLineY;
                r_cnt        <= '0;
                r_state      <= S_SCAN;
                r_rd_en      <= 1'b1;
                r_rd_addr    <= '0;
                r_dvld       <= 1'b0;
                if (w_busy)
                    r_overrun <= 1'b1;
            end else begin
                unique case (r_state)
                    S_SCAN: begin
                        if (r_rd_en) begin
                            if (r_rd_addr == LAST_ADDR)
                                r_rd_en <= 1'b0;
                            else
                                r_rd_addr <= r_rd_addr + 1'b1;
                        end
                        if (r_dvld) begin
                            // Ninth hit: flag it and drop the read in flight.
                            if (w_hit && w_full) begin
                                r_ovf_pend <= 1'b1;
                                r_rd_en    <= 1'b0;
                                r_dvld     <= 1'b0;
                                r_state    <= S_IDLE;
                            end else begin
                                if (w_hit) begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_bank <= ~r_disp_bank;
                                    r_wr_addr <= r_cnt[SLOT_W-1:0];
                                    r_wr_data <= bus.oamData;
                                    r_mask[r_cnt[SLOT_W-1:0]] <= 1'b1;
                                    r_cnt     <= w_cnt_nx;
                                end
                                if (w_last)
                                    r_state <= (w_cnt_nx == CNT_FULL) ? S_IDLE : S_FILL;
                            end
                        end
                    end
                    S_FILL: begin
                        r_wr_en   <= 1'b1;
                        r_wr_bank <= ~r_disp_bank;
                        r_wr_addr <= r_cnt[SLOT_W-1:0];
                        r_wr_data <= EMPTY_SLOT;
                        r_cnt     <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST)
                            r_state <= S_IDLE;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.oamRdEn       = r_rd_en;
    assign bus.oamAddr       = r_rd_addr;
    assign bus.viewWrEn      = r_wr_en;
    assign bus.viewWrBank    = r_wr_bank;
    assign bus.viewWrAddr    = r_wr_addr;
    assign bus.viewWrData    = r_wr_data;
    assign bus.dispBank      = r_disp_bank;
    assign bus.dispSlotValid = r_disp_valid;
    assign bus.evalBusy      = w_busy;
    assign bus.overflow      = r_ovf;
    assign bus.overrun       = r_overrun;

endmodule

// File: tb/tb_sprite_line_eval.sv
// Scoreboard bench: directed lines push expected view writes, a monitor pops them.
module tb_sprite_line_eval;
    import sprite_line_eval_pkg::*;

    typedef struct {
        logic [SLOT_W-1:0] slot;
        logic [31:0]       data;
    } wr_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sprite_line_eval_if bus();

    sprite_line_eval dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    logic [31:0] oam [SPRITE_NUM];
    wr_t         exp_q [$];
    int          nchk = 0;
    int          nerr = 0;

    always @(posedge clk)
        if (bus.oamRdEn)
            bus.oamData <= oam[bus.oamAddr];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic logic [31:0] ent(input int idx, input logic [7:0] py);
        logic [31:0] e;
        e[POSX_LSB +: BYTE] = idx[7:0];
        e[POSY_LSB +: BYTE] = py;
        e[TILE_LSB +: BYTE] = 8'(idx + 'h40);
        e[ATTR_LSB +: BYTE] = 8'h5A;
        return e;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < SPRITE_NUM; i++)
            oam[i] = ent(i, 8'hF0);
    endtask

    task automatic expect_w(input int slot, input logic [31:0] data);
        wr_t w;
        w.slot = SLOT_W'(slot);
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic expect_fill(input int from);
        for (int s = from; s < LINE_SPRITE_MAX; s++)
            expect_w(s, EMPTY_SLOT);
    endtask

    task automatic pulse(input logic [7:0] y);
        @(negedge clk);
        bus.lineStart = 1'b1;
        bus.nextLineY = y;
        @(negedge clk);
        bus.lineStart = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (bus.evalBusy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_in_time"}, 32'(n < 200), 1);
        repeat (2) @(negedge clk);
        chk({nm, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic chk_line(input string nm, input logic bank,
                            input logic [7:0] mask, input logic ovf);
        chk({nm, "_dispBank"}, bus.dispBank, bank);
        chk({nm, "_dispSlotValid"}, bus.dispSlotValid, mask);
        chk({nm, "_overflow"}, bus.overflow, ovf);
        chk({nm, "_evalBusy"}, bus.evalBusy, 1);
    endtask

    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.viewWrEn) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL unexpected_write: slot %0d data %h, none expected",
                             bus.viewWrAddr, bus.viewWrData);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_slot", bus.viewWrAddr, e.slot);
                    chk("wr_data", bus.viewWrData, e.data);
                    chk("wr_bank", bus.viewWrBank, !bus.dispBank);
                end
            end
        end
    end

    initial begin
        bus.lineStart = 1'b0;
        bus.nextLineY = '0;
        clear_oam();

        // lineStart under reset must be ignored
        repeat (3) begin
            @(negedge clk);
            bus.lineStart = 1'b1;
        end
        @(negedge clk);
        chk("rst_oamRd", {bus.oamRdEn, bus.oamAddr}, 0);
        chk("rst_viewWr", {bus.viewWrEn, bus.viewWrBank, bus.viewWrAddr}, 0);
        chk("rst_viewWrData", bus.viewWrData, 0);
        chk("rst_disp", {bus.dispBank, bus.dispSlotValid}, 0);
        chk("rst_flags", {bus.evalBusy, bus.overflow, bus.overrun}, 0);
        bus.lineStart = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", bus.evalBusy, 0);

        // line 20: entries 3 and 10 hit, 40 just misses
        clear_oam();
        oam[3]  = ent(3, 8'd13);
        oam[10] = ent(10, 8'd20);
        oam[40] = ent(40, 8'd12);
        expect_w(0, ent(3, 8'd13));
        expect_w(1, ent(10, 8'd20));
        expect_fill(2);
        pulse(8'd20);
        chk_line("l20", 1'b1, 8'h00, 1'b0);
        chk("l20_oamRdEn", bus.oamRdEn, 1);
        chk("l20_oamAddr", bus.oamAddr, 0);
        wait_idle("l20");

        // line 30: Y-7 hits, Y-8 misses, Y+1 misses, Y hits
        clear_oam();
        oam[5] = ent(5, 8'd23);
        oam[6] = ent(6, 8'd22);
        oam[7] = ent(7, 8'd31);
        oam[8] = ent(8, 8'd30);
        expect_w(0, ent(5, 8'd23));
        expect_w(1, ent(8, 8'd30));
        expect_fill(2);
        pulse(8'd30);
        chk_line("l30", 1'b0, 8'h03, 1'b0);
        wait_idle("l30");

        // line 2: posY 250 must not wrap; last OAM entry hits
        clear_oam();
        oam[0]  = ent(0, 8'd250);
        oam[1]  = ent(1, 8'd0);
        oam[63] = ent(63, 8'd2);
        expect_w(0, ent(1, 8'd0));
        expect_w(1, ent(63, 8'd2));
        expect_fill(2);
        pulse(8'd2);
        chk_line("l2", 1'b1, 8'h03, 1'b0);
        wait_idle("l2");

        // line 50: twelve hits, first eight kept, no fill
        clear_oam();
        for (int i = 0; i < 12; i++)
            oam[i] = ent(i, 8'd50);
        for (int i = 0; i < 8; i++)
            expect_w(i, ent(i, 8'd50));
        pulse(8'd50);
        chk_line("l50", 1'b0, 8'h03, 1'b0);
        wait_idle("l50");

        // line 60: three hits; overflow from line 50 shows now
        clear_oam();
        oam[20] = ent(20, 8'd55);
        oam[21] = ent(21, 8'd60);
        oam[22] = ent(22, 8'd53);
        expect_w(0, ent(20, 8'd55));
        expect_w(1, ent(21, 8'd60));
        expect_w(2, ent(22, 8'd53));
        expect_fill(3);
        pulse(8'd60);
        chk_line("l60", 1'b1, 8'hFF, 1'b1);
        wait_idle("l60");

        // overrun: restart 30 cycles into a scan
        clear_oam();
        oam[3]  = ent(3, 8'd20);
        oam[50] = ent(50, 8'd20);
        expect_w(0, ent(3, 8'd20));
        pulse(8'd20);
        chk_line("ovr1", 1'b0, 8'h07, 1'b0);
        chk("ovr1_overrun", bus.overrun, 0);
        repeat (28) @(negedge clk);
        chk("ovr_partial_drained", exp_q.size(), 0);
        expect_w(0, ent(3, 8'd20));
        expect_w(1, ent(50, 8'd20));
        expect_fill(2);
        pulse(8'd20);
        chk_line("ovr2", 1'b1, 8'h01, 1'b0);
        chk("ovr2_overrun", bus.overrun, 1);
        chk("ovr2_oamAddr", bus.oamAddr, 0);
        chk("ovr2_oamRdEn", bus.oamRdEn, 1);
        wait_idle("ovr2");

        // reset in the middle of a scan
        clear_oam();
        oam[2]  = ent(2, 8'd70);
        oam[40] = ent(40, 8'd70);
        expect_w(0, ent(2, 8'd70));
        pulse(8'd70);
        chk_line("mid", 1'b0, 8'h03, 1'b0);
        chk("mid_overrun_sticky", bus.overrun, 1);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_viewWrEn", bus.viewWrEn, 0);
        chk("mid_rst_evalBusy", bus.evalBusy, 0);
        chk("mid_rst_dispSlotValid", bus.dispSlotValid, 0);
        chk("mid_rst_bank_overrun", {bus.dispBank, bus.overrun}, 0);
        chk("mid_rst_oamRdEn", bus.oamRdEn, 0);
        rstn = 1'b1;
        repeat (80) @(negedge clk);
        chk("mid_no_late_writes", exp_q.size(), 0);

        // first line after reset starts clean
        clear_oam();
        oam[7] = ent(7, 8'd9);
        expect_w(0, ent(7, 8'd9));
        expect_fill(1);
        pulse(8'd9);
        chk_line("after", 1'b1, 8'h00, 1'b0);
        chk("after_overrun", bus.overrun, 0);
        wait_idle("after");

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
